// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging CPU and DMA requests into a single BRAM command port.
// Read returns are steered back to their requester through an in-order tag FIFO.
module mem_req_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_data,
  input  logic              dma_r_ready,
  input  logic [ADDR_W-1:0] dma_r_addr,
  output logic              dma_r_ack,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_data,
  input  logic              dma_w_valid,
  input  logic [ADDR_W-1:0] dma_w_addr,
  input  logic [DATA_W-1:0] dma_w_data,
  output logic              dma_w_ack,
  output logic              bram_in_valid,
  output logic              bram_wr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data_in,
  input  logic              bram_do_valid,
  input  logic [DATA_W-1:0] bram_do,
  output logic              rsp_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  logic [1:0]           rr_ptr_r;
  logic [2:0]           eligible_s;
  logic [2:0]           grant_s;
  logic                 full_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 orphan_s;
  logic                 head_tag_s;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [TAG_DEPTH-1:0] tag_mem_r;
  logic                 bram_in_valid_r;
  logic                 bram_wr_r;
  logic [ADDR_W-1:0]    bram_addr_r;
  logic [DATA_W-1:0]    bram_data_r;
  logic                 rsp_err_r;

  // Full is taken from the registered count so a same-cycle pop never frees a slot early.
  assign full_s     = (count_r == FULL_CNT);
  assign eligible_s = {dma_w_valid,
                       dma_r_ready & ~full_s,
                       cpu_req_valid & (cpu_req_we | ~full_s)};

  // Round-robin search starting at rr_ptr; nothing is granted under reset.
  always_comb begin
    grant_s = 3'b000;
    if (wb_rst_i) begin
      grant_s = 3'b000;
    end else begin
      case (rr_ptr_r)
        2'd1: begin
          if (eligible_s[1])      grant_s = 3'b010;
          else if (eligible_s[2]) grant_s = 3'b100;
          else if (eligible_s[0]) grant_s = 3'b001;
          else                    grant_s = 3'b000;
        end
        2'd2: begin
          if (eligible_s[2])      grant_s = 3'b100;
          else if (eligible_s[0]) grant_s = 3'b001;
          else if (eligible_s[1]) grant_s = 3'b010;
          else                    grant_s = 3'b000;
        end
        default: begin
          if (eligible_s[0])      grant_s = 3'b001;
          else if (eligible_s[1]) grant_s = 3'b010;
          else if (eligible_s[2]) grant_s = 3'b100;
          else                    grant_s = 3'b000;
        end
      endcase
    end
  end

  // Round-robin pointer moves past the winner, holds on idle cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rr_ptr_r <= 2'd0;
    end else begin
      case (grant_s)
        3'b001:  rr_ptr_r <= 2'd1;
        3'b010:  rr_ptr_r <= 2'd2;
        3'b100:  rr_ptr_r <= 2'd0;
        default: rr_ptr_r <= rr_ptr_r;
      endcase
    end
  end

  // Command register toward the BRAM controller; payload holds when idle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bram_in_valid_r <= 1'b0;
      bram_wr_r       <= 1'b0;
      bram_addr_r     <= {ADDR_W{1'b0}};
      bram_data_r     <= {DATA_W{1'b0}};
    end else begin
      bram_in_valid_r <= |grant_s;
      if (grant_s[0]) begin
        bram_wr_r   <= cpu_req_we;
        bram_addr_r <= cpu_req_addr;
        bram_data_r <= cpu_req_wdata;
      end else if (grant_s[1]) begin
        bram_wr_r   <= 1'b0;
        bram_addr_r <= dma_r_addr;
      end else if (grant_s[2]) begin
        bram_wr_r   <= 1'b1;
        bram_addr_r <= dma_w_addr;
        bram_data_r <= dma_w_data;
      end
    end
  end

  assign push_s     = (grant_s[0] & ~cpu_req_we) | grant_s[1];
  assign pop_s      = bram_do_valid & (count_r != {CNT_W{1'b0}}) & ~wb_rst_i;
  assign orphan_s   = bram_do_valid & (count_r == {CNT_W{1'b0}}) & ~wb_rst_i;
  assign head_tag_s = tag_mem_r[rd_ptr_r];

  // Tag FIFO: tag 0 marks a CPU read, tag 1 a DMA read; pointers wrap naturally.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      tag_mem_r <= {TAG_DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant_s[1];
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error for a read return with no outstanding tag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_err_r <= 1'b0;
    end else if (orphan_s) begin
      rsp_err_r <= 1'b1;
    end
  end

  assign cpu_req_ready = grant_s[0];
  assign dma_r_ack     = grant_s[1];
  assign dma_w_ack     = grant_s[2];
  assign cpu_rsp_valid = pop_s & ~head_tag_s;
  assign dma_rsp_valid = pop_s & head_tag_s;
  assign cpu_rsp_data  = bram_do;
  assign dma_rsp_data  = bram_do;
  assign bram_in_valid = bram_in_valid_r;
  assign bram_wr       = bram_wr_r;
  assign bram_addr     = bram_addr_r;
  assign bram_data_in  = bram_data_r;
  assign rsp_err       = rsp_err_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: expected BRAM commands and read sources are
// queued as stimulus is driven and consumed as the design produces them.
module tb_mem_req_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cpu_req_valid, cpu_req_we;
  logic [12:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_req_ready, cpu_rsp_valid;
  logic [31:0] cpu_rsp_data;
  logic        dma_r_ready;
  logic [12:0] dma_r_addr;
  logic        dma_r_ack, dma_rsp_valid;
  logic [31:0] dma_rsp_data;
  logic        dma_w_valid;
  logic [12:0] dma_w_addr;
  logic [31:0] dma_w_data;
  logic        dma_w_ack;
  logic        bram_in_valid, bram_wr;
  logic [12:0] bram_addr;
  logic [31:0] bram_data_in;
  logic        bram_do_valid;
  logic [31:0] bram_do;
  logic        rsp_err;

  mem_req_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_data(cpu_rsp_data),
    .dma_r_ready(dma_r_ready), .dma_r_addr(dma_r_addr), .dma_r_ack(dma_r_ack),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
    .dma_w_valid(dma_w_valid), .dma_w_addr(dma_w_addr), .dma_w_data(dma_w_data),
    .dma_w_ack(dma_w_ack),
    .bram_in_valid(bram_in_valid), .bram_wr(bram_wr), .bram_addr(bram_addr),
    .bram_data_in(bram_data_in),
    .bram_do_valid(bram_do_valid), .bram_do(bram_do), .rsp_err(rsp_err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic        wr;
    logic [12:0] addr;
    logic [31:0] data;
    logic        chk_data;
  } cmd_t;

  cmd_t cmd_q[$];
  logic src_q[$];   // 0 = CPU read, 1 = DMA read, in issue order
  cmd_t mon_c;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Command monitor: every valid BRAM command must match the oldest expected grant.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (bram_in_valid === 1'b1) begin
        if (cmd_q.size() == 0) begin
          check_val("cmd_unexpected", 64'd1, 64'd0);
        end else begin
          mon_c = cmd_q.pop_front();
          check_val("bram_wr", bram_wr, mon_c.wr);
          check_val("bram_addr", bram_addr, mon_c.addr);
          if (mon_c.chk_data) check_val("bram_data_in", bram_data_in, mon_c.data);
        end
      end else if (cmd_q.size() != 0) begin
        check_val("cmd_missing", 64'd0, 64'd1);
        mon_c = cmd_q.pop_front();
      end
    end
  end

  task automatic set_idle();
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = 13'd0; cpu_req_wdata = 32'd0;
    dma_r_ready = 1'b0; dma_r_addr = 13'd0;
    dma_w_valid = 1'b0; dma_w_addr = 13'd0; dma_w_data = 32'd0;
    bram_do_valid = 1'b0; bram_do = 32'd0;
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic cv, input logic cwe, input logic [12:0] ca, input logic [31:0] cd,
                      input logic drv, input logic [12:0] dra,
                      input logic dwv, input logic [12:0] dwa, input logic [31:0] dwd,
                      input logic dov, input logic [31:0] dod, input logic [2:0] exp_ack);
    logic src;
    cpu_req_valid = cv; cpu_req_we = cwe; cpu_req_addr = ca; cpu_req_wdata = cd;
    dma_r_ready = drv; dma_r_addr = dra;
    dma_w_valid = dwv; dma_w_addr = dwa; dma_w_data = dwd;
    bram_do_valid = dov; bram_do = dod;
    @(negedge wb_clk_i);
    check_val("accept", {dma_w_ack, dma_r_ack, cpu_req_ready}, exp_ack);
    if (dov && src_q.size() != 0) begin
      src = src_q.pop_front();
      check_val("cpu_rsp_valid", cpu_rsp_valid, !src);
      check_val("dma_rsp_valid", dma_rsp_valid, src);
    end else begin
      check_val("rsp_valid_idle", {cpu_rsp_valid, dma_rsp_valid}, 64'd0);
    end
    if (dov) begin
      check_val("cpu_rsp_data", cpu_rsp_data, dod);
      check_val("dma_rsp_data", dma_rsp_data, dod);
    end
    @(posedge wb_clk_i); #1;
    if (exp_ack[0]) cmd_q.push_back('{cwe, ca, cd, 1'b1});
    if (exp_ack[1]) cmd_q.push_back('{1'b0, dra, 32'd0, 1'b0});
    if (exp_ack[2]) cmd_q.push_back('{1'b1, dwa, dwd, 1'b1});
    if (exp_ack[0] && !cwe) src_q.push_back(1'b0);
    if (exp_ack[1]) src_q.push_back(1'b1);
    set_idle();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 13'd0, 32'd0, 1'b0, 13'd0, 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b000);
  endtask

  task automatic ret(input logic [31:0] d);
    step(1'b0, 1'b0, 13'd0, 32'd0, 1'b0, 13'd0, 1'b0, 13'd0, 32'd0, 1'b1, d, 3'b000);
  endtask

  // Single-cycle reset pulse with every input active.
  task automatic do_reset();
    wb_rst_i = 1'b1;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; dma_r_ready = 1'b1; dma_w_valid = 1'b1;
    bram_do_valid = 1'b1; bram_do = 32'h5A5A_5A5A;
    @(negedge wb_clk_i);
    check_val("rst_accept", {dma_w_ack, dma_r_ack, cpu_req_ready}, 64'd0);
    check_val("rst_rsp_valid", {cpu_rsp_valid, dma_rsp_valid}, 64'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    set_idle();
    cmd_q.delete();
    src_q.delete();
    @(negedge wb_clk_i);
    check_val("rst_bram_in_valid", bram_in_valid, 64'd0);
    check_val("rst_bram_wr", bram_wr, 64'd0);
    check_val("rst_bram_addr", bram_addr, 64'd0);
    check_val("rst_bram_data_in", bram_data_in, 64'd0);
    check_val("rst_rsp_err", rsp_err, 64'd0);
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    set_idle();
    repeat (2) @(posedge wb_clk_i);
    #1;
    do_reset();

    // Three-way contention straight out of reset: CPU, DMA-read, DMA-write, repeating.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 13'(i), 32'h1000_0000 + 32'(i),
           1'b1, 13'h100 + 13'(i),
           1'b1, 13'h200 + 13'(i), 32'hA000_0000 + 32'(i),
           1'b0, 32'd0, 3'b001 << (i % 3));
    end
    idle_step();
    ret(32'h0000_0B01); ret(32'h0000_0B02); ret(32'h0000_0B03);

    // Solo CPU write then read of the same word.
    step(1'b1, 1'b1, 13'h010, 32'hDEAD_BEEF, 1'b0, 13'd0, 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b001);
    step(1'b1, 1'b0, 13'h010, 32'd0, 1'b0, 13'd0, 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b001);
    idle_step();
    check_val("hold_addr", bram_addr, 64'h010);
    check_val("hold_wr", bram_wr, 64'd0);
    ret(32'hDEAD_BEEF);

    // Mixed returns: reads CPU, DMA, DMA, CPU answered by 1..4.
    step(1'b1, 1'b0, 13'h020, 32'd0, 1'b0, 13'd0,   1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b001);
    step(1'b0, 1'b0, 13'd0,   32'd0, 1'b1, 13'h021, 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b010);
    step(1'b0, 1'b0, 13'd0,   32'd0, 1'b1, 13'h022, 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b010);
    step(1'b1, 1'b0, 13'h023, 32'd0, 1'b0, 13'd0,   1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b001);
    for (int i = 1; i <= 4; i++) ret(32'(i));

    // FIFO full: four DMA reads, then a fifth stalls while a DMA write still goes through.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 13'd0, 32'd0, 1'b1, 13'h040 + 13'(i), 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b010);
    end
    step(1'b0, 1'b0, 13'd0, 32'd0, 1'b1, 13'h044, 1'b1, 13'h050, 32'h5555_AAAA, 1'b0, 32'd0, 3'b100);
    step(1'b1, 1'b0, 13'h060, 32'd0, 1'b1, 13'h044, 1'b0, 13'd0, 32'd0, 1'b1, 32'h0000_00C0, 3'b000);
    step(1'b0, 1'b0, 13'd0, 32'd0, 1'b1, 13'h044, 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b010);
    for (int i = 1; i <= 4; i++) ret(32'h0000_00C0 + 32'(i));

    // Orphan response is dropped and latches rsp_err until reset.
    check_val("rsp_err_clear", rsp_err, 64'd0);
    ret(32'hBAD0_0001);
    check_val("rsp_err_set", rsp_err, 64'd1);
    idle_step(); idle_step();
    check_val("rsp_err_sticky", rsp_err, 64'd1);
    do_reset();

    // Reset with three reads outstanding: tags discarded, pointer back at CPU.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 13'h070 + 13'(i), 32'd0, 1'b0, 13'd0, 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b001);
    end
    step(1'b0, 1'b0, 13'd0, 32'd0, 1'b1, 13'h080, 1'b0, 13'd0, 32'd0, 1'b0, 32'd0, 3'b010);
    idle_step();
    do_reset();
    ret(32'hBAD0_0002);
    check_val("mid_reset_orphan", rsp_err, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 13'h090 + 13'(i), 32'h9000_0000 + 32'(i),
           1'b1, 13'h0A0 + 13'(i),
           1'b1, 13'h0B0 + 13'(i), 32'hB000_0000 + 32'(i),
           1'b0, 32'd0, 3'b001 << i);
    end
    idle_step();
    ret(32'h0000_0D01);
    idle_step();

    check_val("cmd_q_drained", cmd_q.size(), 64'd0);
    check_val("src_q_drained", src_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, BRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TAG_DEPTH, default 4, maximum outstanding reads; power of two, at least 2.
REQ-004 SHALL have port wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports cpu_req_valid in 1, cpu_req_we in 1 (1=write), cpu_req_addr in ADDR_W, cpu_req_wdata in DATA_W: the CPU request.
REQ-007 SHALL have port cpu_req_ready  out  1  CPU request accepted this cycle.
REQ-008 SHALL have ports cpu_rsp_valid out 1 and cpu_rsp_data out DATA_W: CPU read return.
REQ-009 SHALL have ports dma_r_ready in 1 and dma_r_addr in ADDR_W: DMA read request.
REQ-010 SHALL have port dma_r_ack  out  1  DMA read accepted.
REQ-011 SHALL have ports dma_rsp_valid out 1 and dma_rsp_data out DATA_W: DMA read return.
REQ-012 SHALL have ports dma_w_valid in 1, dma_w_addr in ADDR_W, dma_w_data in DATA_W: DMA write request.
REQ-013 SHALL have port dma_w_ack  out  1  DMA write accepted.
REQ-014 SHALL have ports bram_in_valid out 1, bram_wr out 1, bram_addr out ADDR_W, bram_data_in out DATA_W: the command to the BRAM controller.
REQ-015 SHALL have ports bram_do_valid in 1 and bram_do in DATA_W: the in-order read return from the BRAM controller.
REQ-016 SHALL have port rsp_err  out  1  sticky flag for an orphan response.

Function
REQ-017 SHALL define three requesters with indices 0=CPU, 1=DMA-read, 2=DMA-write; a requester is eligible when its valid/ready input is high.
REQ-018 SHALL treat a read as eligible only when the tag FIFO is not full; writes are never blocked by the FIFO.
REQ-019 SHALL grant at most one eligible requester per cycle using round-robin from rr_ptr: search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
REQ-020 SHALL set rr_ptr to (granted index + 1) mod 3 on a grant, and leave rr_ptr unchanged on a cycle with no grant.
REQ-021 SHALL raise the accept output (cpu_req_ready, dma_r_ack or dma_w_ack) combinationally in the grant cycle; it is high only for the granted requester.
REQ-022 SHALL register the granted command, so the outputs in the next cycle are bram_in_valid=1, bram_wr set for a CPU write or DMA write, and bram_addr/bram_data_in equal to the granted address/data.
REQ-023 SHALL drive bram_in_valid=0 in the next cycle when there is no grant, with bram_wr, bram_addr and bram_data_in holding their last values.
REQ-024 SHALL give a command latency of exactly 1 cycle from accept to bram_in_valid.
REQ-025 SHALL push one tag per granted read into the tag FIFO (TAG_DEPTH entries, in order): tag 0 = CPU, tag 1 = DMA.
REQ-026 SHALL, on bram_do_valid=1 with the FIFO non-empty, pop the head tag in that cycle.
REQ-027 SHALL route each popped response combinationally in the same cycle: tag 0 gives cpu_rsp_valid=1 and cpu_rsp_data=bram_do; tag 1 gives dma_rsp_valid=1 and dma_rsp_data=bram_do.
REQ-028 SHALL drive both rsp_valid outputs 0 when no response is being popped; the rsp_data outputs equal bram_do at all times.
REQ-029 SHALL, on bram_do_valid=1 with the FIFO empty, drop the response, assert no rsp_valid and set rsp_err=1; rsp_err then stays 1 until reset.
REQ-030 SHALL, on a push and a pop in the same cycle, keep the FIFO count unchanged and return the entries in FIFO order; this also holds when the FIFO is full.
REQ-031 SHALL evaluate the full flag on the registered count, so no read is granted when count==TAG_DEPTH, even if a pop occurs in that cycle.
REQ-032 SHALL wrap the FIFO read/write pointers modulo TAG_DEPTH.
REQ-033 SHALL honour a requester that drops its valid before being granted; it is ignored and no state changes.
REQ-034 SHALL never give a CPU request read-before-write ordering with respect to its own writes; ordering follows the grant order and the BRAM controller executes commands in order.

Reset
REQ-035 SHALL, while wb_rst_i=1, clear bram_in_valid, bram_wr, bram_addr, bram_data_in, rr_ptr, the FIFO pointers/count and rsp_err to 0.
REQ-036 SHALL force all accept outputs and all rsp_valid outputs to 0 while wb_rst_i=1.
REQ-037 SHALL discard outstanding tags on reset mid-operation.
REQ-038 SHALL treat any bram_do_valid arriving after reset with an empty FIFO as an orphan, setting rsp_err per REQ-029.

Verification
REQ-039 Scenario "solo": CPU write addr 0x010 data 0xDEADBEEF, then CPU read 0x010 -> cpu_req_ready 1 cycle each; next cycle bram_in_valid=1, bram_wr=1 then bram_wr=0, bram_addr=0x010; when bram_do_valid=1 with 0xDEADBEEF, cpu_rsp_valid=1 with the same data.
REQ-040 Scenario "three-way contention": all three requesters valid continuously from reset -> grants cycle CPU, DMA-read, DMA-write, CPU, ...; each requester is granted exactly once every 3 cycles.
REQ-041 Scenario "FIFO full": TAG_DEPTH=4, 4 DMA reads with no returns -> 5th dma_r_ready stalls with dma_r_ack=0 while a concurrent dma_w_valid is still acked; one return frees the slot and the read is acked in the next cycle.
REQ-042 Scenario "mixed returns": issue reads in order CPU, DMA, DMA, CPU with returns 0x1,0x2,0x3,0x4 -> cpu_rsp gets 0x1 and 0x4, dma_rsp gets 0x2 and 0x3, in order.
REQ-043 Scenario "orphan response": bram_do_valid=1 with the FIFO empty -> no rsp_valid and rsp_err=1 until reset.
REQ-044 Scenario "reset mid-flight": 3 reads outstanding, wb_rst_i pulsed 1 cycle -> count=0 and rr_ptr=0; a following return sets rsp_err.
